// File: rtl/mem_access_ctrl_pkg.sv
// Shared types and helpers for the byte-cell memory access controller.
package mem_access_pkg;

  localparam int CNT_W     = 3;
  localparam int SEL_MAX_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    WR_DRIVE,
    RD_DRIVE,
    VFY_DRIVE,
    RESP
  } state_e;

  // Full-width one-hot; callers truncate to their cell count.
  function automatic logic [SEL_MAX_W-1:0] onehot(input logic [4:0] idx);
    onehot = {{(SEL_MAX_W-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/mem_addr_decoder.sv
// Combinational byte-index decoder: one-hot cell select plus in-range flag.
module mem_addr_decoder #(
  parameter int ADDR_W    = 2,
  parameter int NUM_BYTES = 4
) (
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic                 en_i,
  output logic [NUM_BYTES-1:0] sel_o,
  output logic                 in_range_o
);
  import mem_access_pkg::*;

  always_comb begin
    in_range_o = (32'(addr_i) < NUM_BYTES);
    sel_o      = '0;
    if (en_i && in_range_o) begin
      sel_o = NUM_BYTES'(onehot(5'(addr_i)));
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Request/response controller for the shared-bus byte-cell array.
// Optional write read-back check built with MEM_ACCESS_WRITE_VERIFY_EN.
module mem_access_ctrl #(
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 2,
  parameter int NUM_BYTES     = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic [NUM_BYTES-1:0] mem_wr_sel,
  output logic                 mem_rd_en,
  output logic [NUM_BYTES-1:0] mem_rd_sel,
  input  logic [DATA_W-1:0]    mem_rdata
);
  import mem_access_pkg::*;

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [DATA_W-1:0]    rdata_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic                 rsp_err_q;
  logic                 rd_en_q;
  logic [NUM_BYTES-1:0] wr_sel_q;
  logic [NUM_BYTES-1:0] rd_sel_q;

  logic [ADDR_W-1:0]    dec_addr;
  logic [NUM_BYTES-1:0] dec_sel;
  logic                 dec_in_range;

  // The decoder sees the live request while idle, the held address afterwards.
  assign dec_addr = (state_q == IDLE) ? req_addr : addr_q;

  mem_addr_decoder #(
    .ADDR_W    (ADDR_W),
    .NUM_BYTES (NUM_BYTES)
  ) u_dec (
    .addr_i     (dec_addr),
    .en_i       (1'b1),
    .sel_o      (dec_sel),
    .in_range_o (dec_in_range)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      cnt_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_en_q     <= 1'b0;
      wr_sel_q    <= '0;
      rd_sel_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr;
            req_ready_q <= 1'b0;
            if (!dec_in_range) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rdata_q     <= '0;
            end else if (req_we) begin
              state_q  <= WR_DRIVE;
              wdata_q  <= req_wdata;
              wr_sel_q <= dec_sel;
            end else begin
              state_q  <= RD_DRIVE;
              rd_en_q  <= 1'b1;
              rd_sel_q <= dec_sel;
              cnt_q    <= CNT_W'(SETTLE_CYCLES);
            end
          end
        end
        WR_DRIVE: begin
          wr_sel_q <= '0;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
          state_q  <= VFY_DRIVE;
          rd_en_q  <= 1'b1;
          rd_sel_q <= dec_sel;
          cnt_q    <= CNT_W'(SETTLE_CYCLES);
`else
          state_q     <= RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rdata_q     <= '0;
`endif
        end
        RD_DRIVE, VFY_DRIVE: begin
          // Bus is sampled on the edge that ends the final settle cycle.
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            state_q     <= RESP;
            rd_en_q     <= 1'b0;
            rd_sel_q    <= '0;
            rsp_valid_q <= 1'b1;
            rdata_q     <= mem_rdata;
            rsp_err_q   <= (state_q == VFY_DRIVE) && (mem_rdata != wdata_q);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rdata_q;
  assign rsp_err    = rsp_err_q;
  assign mem_wdata  = wdata_q;
  assign mem_wr_sel = wr_sel_q;
  assign mem_rd_en  = rd_en_q;
  assign mem_rd_sel = rd_sel_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed table, corner sequences, random traffic vs reference model.
module tb_mem_access_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
  localparam int NB = 3;
  localparam int S  = 1;
`ifdef MEM_ACCESS_WRITE_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif
  localparam int WR_LAT = VFY ? (2 + S + 1) : 2;
  localparam int RD_LAT = S + 2;
  localparam int WR_RDC = VFY ? (S + 1) : 0;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic [DW-1:0] mem_wdata;
  logic [NB-1:0] mem_wr_sel;
  logic          mem_rd_en;
  logic [NB-1:0] mem_rd_sel;
  logic [DW-1:0] mem_rdata;

  mem_access_ctrl #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_BYTES(NB), .SETTLE_CYCLES(S)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_wdata(mem_wdata), .mem_wr_sel(mem_wr_sel), .mem_rd_en(mem_rd_en),
    .mem_rd_sel(mem_rd_sel), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-cell array stand-in: cells capture on their strobe, drive the bus only when selected.
  logic [DW-1:0] cells [NB];
  logic [DW-1:0] corrupt;
  logic          clr;

  always @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (clr) cells[i] <= '0;
      else if (mem_wr_sel[i]) cells[i] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = 8'h00;
    if (mem_rd_en && $onehot(mem_rd_sel)) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_rd_sel[i]) mem_rdata = cells[i] ^ corrupt;
      end
    end
  end

  int viol;
  always @(negedge clk) begin
    if (rst_n) begin
      if ((mem_wr_sel != '0 && mem_rd_sel != '0) || (!mem_rd_en && mem_rd_sel != '0))
        viol <= viol + 1;
    end
  end

  int checks;
  int errors;
  logic [DW-1:0] ref_mem [NB];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference behaviour derived from transaction type alone.
  task automatic model(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       output logic err, output logic [DW-1:0] rd, output int lat,
                       output int wr, output int rdc);
    if (int'(addr) >= NB) begin
      err = 1'b1; rd = '0; lat = 1; wr = 0; rdc = 0;
    end else if (we) begin
      ref_mem[addr] = wd;
      err = 1'b0; rd = VFY ? wd : '0; lat = WR_LAT; wr = 1; rdc = WR_RDC;
    end else begin
      err = 1'b0; rd = ref_mem[addr]; lat = RD_LAT; wr = 0; rdc = S + 1;
    end
  endtask

  task automatic run_txn(input string nm, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd, input int hold, input logic exp_err,
                         input logic [DW-1:0] exp_rd, input int exp_lat,
                         input int exp_wr, input int exp_rdc);
    int lat, wr_cnt, rd_cnt, w;
    logic [NB-1:0] wr_seen, rd_seen, exp_sel;
    logic [DW-1:0] wd_seen, got_rd;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk({nm, "_ready"}, 32'(req_ready), 32'd1);
      return;
    end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = AW'($urandom); req_wdata = DW'($urandom);
    lat = 0; wr_cnt = 0; rd_cnt = 0; wr_seen = '0; rd_seen = '0; wd_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (mem_wr_sel != '0) begin wr_cnt++; wr_seen = mem_wr_sel; wd_seen = mem_wdata; end
      if (mem_rd_en) begin rd_cnt++; rd_seen = mem_rd_sel; end
      if (rsp_valid) begin lat = k; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    if (lat == 0) return;
    got_rd = rsp_rdata;
    chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
    chk({nm, "_rdata"}, 32'(rsp_rdata), 32'(exp_rd));
    chk({nm, "_wrcnt"}, 32'(wr_cnt), 32'(exp_wr));
    chk({nm, "_rdcnt"}, 32'(rd_cnt), 32'(exp_rdc));
    exp_sel = NB'(1) << addr;
    if (exp_wr > 0) begin
      chk({nm, "_wrsel"}, 32'(wr_seen), 32'(exp_sel));
      chk({nm, "_wdata"}, 32'(wd_seen), 32'(wd));
    end
    if (exp_rdc > 0) chk({nm, "_rdsel"}, 32'(rd_seen), 32'(exp_sel));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({nm, "_hold_vld"}, 32'(rsp_valid), 32'd1);
      chk({nm, "_hold_rdata"}, 32'(rsp_rdata), 32'(got_rd));
      chk({nm, "_hold_rdy"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_post_vld"}, 32'(rsp_valid), 32'd0);
    chk({nm, "_post_rdy"}, 32'(req_ready), 32'd1);
    chk({nm, "_post_rdata"}, 32'(rsp_rdata), 32'd0);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    int            hold;
    logic          err;
    logic [DW-1:0] rd;
    int            lat;
    int            wr;
    int            rdc;
  } vec_t;

  vec_t tbl [6];

  initial begin
    logic          m_err;
    logic [DW-1:0] m_rd;
    int            m_lat, m_wr, m_rdc, stale;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wd;

    checks = 0; errors = 0; viol = 0; corrupt = '0; clr = 1'b1;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    for (int i = 0; i < NB; i++) ref_mem[i] = '0;

    tbl[0] = '{1'b1, 2'd2, 8'hA5, 0, 1'b0, (VFY ? 8'hA5 : 8'h00), WR_LAT, 1, WR_RDC};
    tbl[1] = '{1'b1, 2'd1, 8'h3C, 1, 1'b0, (VFY ? 8'h3C : 8'h00), WR_LAT, 1, WR_RDC};
    tbl[2] = '{1'b0, 2'd1, 8'h00, 0, 1'b0, 8'h3C, RD_LAT, 0, S + 1};
    tbl[3] = '{1'b0, 2'd2, 8'h00, 5, 1'b0, 8'hA5, RD_LAT, 0, S + 1};
    tbl[4] = '{1'b1, 2'd3, 8'h77, 0, 1'b1, 8'h00, 1, 0, 0};
    tbl[5] = '{1'b0, 2'd3, 8'h00, 2, 1'b1, 8'h00, 1, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_wr_sel", 32'(mem_wr_sel), 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_rd_sel", 32'(mem_rd_sel), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("tbl%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].hold,
              tbl[i].err, tbl[i].rd, tbl[i].lat, tbl[i].wr, tbl[i].rdc);
      if (tbl[i].we && int'(tbl[i].addr) < NB) ref_mem[tbl[i].addr] = tbl[i].wd;
    end

    // Reset while the read select is being held.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 2'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("midrst_rd_en_before", 32'(mem_rd_en), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("midrst_rd_sel", 32'(mem_rd_sel), 32'd0);
    chk("midrst_wr_sel", 32'(mem_wr_sel), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    stale = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (rsp_valid) stale++;
    end
    chk("midrst_stale_rsp", 32'(stale), 32'd0);
    model(1'b0, 2'd2, 8'h00, m_err, m_rd, m_lat, m_wr, m_rdc);
    run_txn("midrst_after", 1'b0, 2'd2, 8'h00, 0, m_err, m_rd, m_lat, m_wr, m_rdc);

    // Write read-back with a corrupted bus, then a clean one.
    corrupt = 8'h01;
    ref_mem[0] = 8'hFF;
    run_txn("vfy_bad", 1'b1, 2'd0, 8'hFF, 0, (VFY ? 1'b1 : 1'b0), (VFY ? 8'hFE : 8'h00),
            WR_LAT, 1, WR_RDC);
    corrupt = 8'h00;
    run_txn("vfy_ok", 1'b1, 2'd0, 8'hFF, 0, 1'b0, (VFY ? 8'hFF : 8'h00), WR_LAT, 1, WR_RDC);

    for (int n = 0; n < 60; n++) begin
      r_we   = 1'($urandom);
      r_addr = AW'($urandom_range(0, 3));
      r_wd   = DW'($urandom);
      model(r_we, r_addr, r_wd, m_err, m_rd, m_lat, m_wr, m_rdc);
      run_txn($sformatf("rnd%0d", n), r_we, r_addr, r_wd, int'($urandom_range(0, 3)),
              m_err, m_rd, m_lat, m_wr, m_rdc);
    end

    @(negedge clk);
    chk("strobe_rules", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
